// File: rtl/rv_isa_pkg.sv
// -----------------------------------------------------------------------------
// rv_isa_pkg
// Shared RV32I encoding definitions for the instruction encoder:
//   - major opcode constants
//   - instruction format enumeration
//   - canonical NOP word (addi x0, x0, 0)
//   - signed immediate range limits per format
//   - decode_fmt(): maps a 7-bit opcode to its instruction format
// -----------------------------------------------------------------------------
package rv_isa_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // I/S: 12-bit signed. B: 13-bit signed, even. J: 21-bit signed, even.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    function automatic fmt_e decode_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP:                  fmt = FMT_R;
            OP_IMM, LOAD, JALR:  fmt = FMT_I;
            STORE:               fmt = FMT_S;
            BRANCH:              fmt = FMT_B;
            LUI, AUIPC:          fmt = FMT_U;
            JAL:                 fmt = FMT_J;
            default:             fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_packer.sv
// -----------------------------------------------------------------------------
// imm_packer
// Combinational immediate scatter and range/alignment check.
// Ports:
//   i_fmt        instruction format
//   i_imm        32-bit signed immediate (U-type: full 32-bit value)
//   o_imm_bits   immediate bits placed at their instruction-word positions,
//                every other bit zero (OR-ed with the register/function fields)
//   o_range_err  immediate not representable in the format; never set for
//                R-type or FMT_BAD (an illegal opcode is flagged by the caller)
// -----------------------------------------------------------------------------
module imm_packer
    import rv_isa_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_bits,
    output logic        o_range_err
);

    logic signed [31:0] w_imm_s;
    assign w_imm_s = i_imm;

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        o_imm_bits  = '0;
        o_range_err = 1'b0;
        case (i_fmt)
            FMT_I: begin
                o_imm_bits[31:20] = i_imm[11:0];
                o_range_err       = (w_imm_s < IMM12_MIN) || (w_imm_s > IMM12_MAX);
            end
            FMT_S: begin
                o_imm_bits[31:25] = i_imm[11:5];
                o_imm_bits[11:7]  = i_imm[4:0];
                o_range_err       = (w_imm_s < IMM12_MIN) || (w_imm_s > IMM12_MAX);
            end
            FMT_B: begin
                o_imm_bits[31]    = i_imm[12];
                o_imm_bits[30:25] = i_imm[10:5];
                o_imm_bits[11:8]  = i_imm[4:1];
                o_imm_bits[7]     = i_imm[11];
                o_range_err       = (w_imm_s < IMM13_MIN) || (w_imm_s > IMM13_MAX)
                                    || i_imm[0];
            end
            FMT_U: begin
                o_imm_bits[31:12] = i_imm[31:12];
                o_range_err       = (i_imm[11:0] != 12'h000);
            end
            FMT_J: begin
                o_imm_bits[31]    = i_imm[20];
                o_imm_bits[30:21] = i_imm[10:1];
                o_imm_bits[20]    = i_imm[11];
                o_imm_bits[19:12] = i_imm[19:12];
                o_range_err       = (w_imm_s < IMM21_MIN) || (w_imm_s > IMM21_MAX)
                                    || i_imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Streaming RV32I encoder: packs opcode, register/function fields and a signed
// immediate into a 32-bit instruction word tagged with an auto-incrementing
// write address. Two-stage valid/ready pipeline; illegal opcodes and
// out-of-range/misaligned immediates emit a NOP with out_err set.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   clear                pulse: address counter and err_count to start values
//   in_valid/in_ready    input handshake
//   in_opcode..in_imm    raw instruction fields
//   out_valid/out_ready  output handshake
//   out_instr, out_addr  encoded word and its write address
//   out_err              word was replaced by NOP
//   err_count            saturating count of accepted error words
// -----------------------------------------------------------------------------
module instruction_encoder
    import rv_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    // Stage 1: raw fields
    logic        r_s1_valid;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [6:0]  r_s1_funct7;
    logic [31:0] r_s1_imm;

    // Stage 2: encoded word
    logic                 r_s2_valid;
    logic [31:0]          r_out_instr;
    logic [31:0]          r_out_addr;
    logic                 r_out_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [31:0]          r_addr;

    logic        w_s1_advance;
    logic        w_in_fire;
    logic        w_s2_load;
    logic        w_out_fire;
    fmt_e        w_fmt;
    logic [31:0] w_imm_bits;
    logic        w_range_err;
    logic [31:0] w_fields;
    logic        w_err;
    logic [31:0] w_instr;
    logic [31:0] w_addr_base;

    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;
    assign w_s2_load    = r_s1_valid && w_s1_advance;
    assign w_out_fire   = r_s2_valid && out_ready;

    assign w_fmt = decode_fmt(r_s1_opcode);

    imm_packer u_imm_packer (
        .i_fmt       (w_fmt),
        .i_imm       (r_s1_imm),
        .o_imm_bits  (w_imm_bits),
        .o_range_err (w_range_err)
    );

    // Only the fields a format actually uses reach the word.
    always_comb begin
        w_fields = '0;
        case (w_fmt)
            FMT_R:        w_fields = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                      r_s1_rd, r_s1_opcode};
            FMT_I:        w_fields = {12'b0, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_S, FMT_B: w_fields = {7'b0, r_s1_rs2, r_s1_rs1, r_s1_funct3, 5'b0,
                                      r_s1_opcode};
            FMT_U, FMT_J: w_fields = {20'b0, r_s1_rd, r_s1_opcode};
            default:      w_fields = '0;
        endcase
    end

    assign w_err   = (w_fmt == FMT_BAD) || w_range_err;
    assign w_instr = w_err ? NOP_INSTR : (w_fields | w_imm_bits);

    // A clear coinciding with a stage-2 load restarts numbering at that word.
    assign w_addr_base = clear ? BASE_ADDR : r_addr;

    // NOTE: stage-1 payload carries no reset; r_s1_valid qualifies it, so
    // stale contents are never observed and the flops stay reset-free.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_opcode <= in_opcode;
            r_s1_rd     <= in_rd;
            r_s1_rs1    <= in_rs1;
            r_s1_rs2    <= in_rs2;
            r_s1_funct3 <= in_funct3;
            r_s1_funct7 <= in_funct7;
            r_s1_imm    <= in_imm;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= BASE_ADDR;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
            r_addr      <= BASE_ADDR;
        end else begin
            r_s1_valid <= w_in_fire || (r_s1_valid && !w_s1_advance);
            r_s2_valid <= w_s2_load || (r_s2_valid && !out_ready);

            if (w_s2_load) begin
                r_out_instr <= w_instr;
                r_out_err   <= w_err;
                r_out_addr  <= w_addr_base;
                r_addr      <= w_addr_base + ADDR_STEP;
            end else if (clear) begin
                r_addr <= BASE_ADDR;
            end

            if (clear) begin
                r_err_count <= '0;
            end else if (w_out_fire && r_out_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import rv_isa_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [7:0]  err_count;

    instruction_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        chk;   // 1: compare full word; 0: round-trip decode
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        fmt_e        fmt;
        logic [31:0] imm;
        logic [6:0]  op;
    } exp_t;

    exp_t       exp_q[$];
    logic [31:0] exp_addr;
    logic [7:0]  exp_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        tbl[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent RV32I immediate decoder for round-trip checks.
    function automatic logic [31:0] dec_imm(input fmt_e f, input logic [31:0] w);
        case (f)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   return {w[31:12], 12'b0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Output monitor: compares each word on the cycle it is accepted.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("addr", out_addr, e.addr);
                check("err", {31'b0, out_err}, {31'b0, e.err});
                if (e.chk) begin
                    check("instr", out_instr, e.instr);
                end else begin
                    check("rt_imm", dec_imm(e.fmt, out_instr), e.imm);
                    check("rt_opcode", {25'b0, out_instr[6:0]}, {25'b0, e.op});
                end
            end
        end
    end

    task automatic drive_word(input vec_t v, input logic chk, input fmt_e f);
        exp_t e;
        logic acc;
        e.chk = chk; e.instr = v.exp_instr; e.addr = exp_addr; e.err = v.exp_err;
        e.fmt = f;   e.imm = v.imm;         e.op = v.op;
        exp_q.push_back(e);
        exp_addr = exp_addr + STEP;
        if (v.exp_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid  = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        fmt_e f;
        int   t;
        logic [31:0] u;

        //           op      rd   rs1  rs2  f3    f7     imm            exp_instr      err
        tbl[0]  = '{OP_IMM, 5'd1, 5'd0, 5'd31,3'd0,7'h7F, 32'd5,         32'h00500093, 1'b0};
        tbl[1]  = '{OP,     5'd3, 5'd1, 5'd2, 3'd0,7'h00, 32'd0,         32'h002081B3, 1'b0};
        tbl[2]  = '{OP,     5'd3, 5'd1, 5'd2, 3'd0,7'h20, 32'h00012345,  32'h402081B3, 1'b0};
        tbl[3]  = '{OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,7'h00, 32'hFFFFF800,  32'h80000093, 1'b0};
        tbl[4]  = '{OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,7'h00, 32'd2047,      32'h7FF00093, 1'b0};
        tbl[5]  = '{OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,7'h00, 32'hFFFFF7FF,  NOP_INSTR,    1'b1};
        tbl[6]  = '{OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0,7'h00, 32'd2048,      NOP_INSTR,    1'b1};
        tbl[7]  = '{LOAD,   5'd5, 5'd2, 5'd0, 3'd2,7'h00, 32'hFFFFFFFC,  32'hFFC12283, 1'b0};
        tbl[8]  = '{JALR,   5'd0, 5'd1, 5'd0, 3'd0,7'h00, 32'd0,         32'h00008067, 1'b0};
        tbl[9]  = '{STORE,  5'd31,5'd1, 5'd2, 3'd2,7'h7F, 32'd12,        32'h0020A623, 1'b0};
        tbl[10] = '{STORE,  5'd0, 5'd0, 5'd0, 3'd2,7'h00, 32'hFFFFF800,  32'h80002023, 1'b0};
        tbl[11] = '{STORE,  5'd0, 5'd0, 5'd0, 3'd2,7'h00, 32'd2048,      NOP_INSTR,    1'b1};
        tbl[12] = '{BRANCH, 5'd31,5'd1, 5'd2, 3'd0,7'h7F, 32'hFFFFFFF8,  32'hFE208CE3, 1'b0};
        tbl[13] = '{BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'd4094,      32'h7E000FE3, 1'b0};
        tbl[14] = '{BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'hFFFFF000,  32'h80000063, 1'b0};
        tbl[15] = '{BRANCH, 5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'd4096,      NOP_INSTR,    1'b1};
        tbl[16] = '{BRANCH, 5'd0, 5'd1, 5'd2, 3'd0,7'h00, 32'hFFFFFFF9,  NOP_INSTR,    1'b1};
        tbl[17] = '{JAL,    5'd1, 5'd31,5'd31,3'd7,7'h7F, 32'd2048,      32'h001000EF, 1'b0};
        tbl[18] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'h000FFFFE,  32'h7FFFF06F, 1'b0};
        tbl[19] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'hFFF00000,  32'h8000006F, 1'b0};
        tbl[20] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'h00100000,  NOP_INSTR,    1'b1};
        tbl[21] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'd3,         NOP_INSTR,    1'b1};
        tbl[22] = '{LUI,    5'd5, 5'd31,5'd0, 3'd7,7'h00, 32'h12345000,  32'h123452B7, 1'b0};
        tbl[23] = '{AUIPC,  5'd1, 5'd0, 5'd0, 3'd0,7'h00, 32'hFFFFF000,  32'hFFFFF097, 1'b0};
        tbl[24] = '{LUI,    5'd1, 5'd0, 5'd0, 3'd0,7'h00, 32'h00001001,  NOP_INSTR,    1'b1};
        tbl[25] = '{7'h7F,  5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'd0,         NOP_INSTR,    1'b1};
        tbl[26] = '{OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0,7'h00, 32'd0,         NOP_INSTR,    1'b0};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        exp_addr = BASE; exp_cnt = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_err_count", {24'b0, err_count}, 32'd0);

        // addi x1,x0,5: two-cycle latency
        @(posedge clk); #1;
        drive_word(tbl[0], 1'b1, FMT_I);
        @(negedge clk);
        check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
        wait_drain();

        // beq then sw back-to-back
        drive_word(tbl[12], 1'b1, FMT_B);
        drive_word(tbl[9], 1'b1, FMT_S);
        wait_drain();

        // Directed vectors, one word at a time
        for (int k = 0; k < 27; k++) begin
            drive_word(tbl[k], 1'b1, FMT_R);
            wait_drain();
            check("err_count", {24'b0, err_count}, {24'b0, exp_cnt});
        end

        // Backpressure: 4-word stream, downstream stalled
        out_ready = 1'b0;
        u = exp_addr;
        fork
            begin
                drive_word(tbl[13], 1'b1, FMT_R);
                drive_word(tbl[9],  1'b1, FMT_R);
                drive_word(tbl[22], 1'b1, FMT_R);
                drive_word(tbl[1],  1'b1, FMT_R);
            end
            begin
                @(posedge clk); @(posedge clk); @(negedge clk);
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                check("stall_out_valid", {31'b0, out_valid}, 32'd1);
                repeat (3) begin
                    @(negedge clk);
                    check("hold_instr", out_instr, tbl[13].exp_instr);
                    check("hold_addr", out_addr, u);
                    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // clear coinciding with an accepted error word and a stage-2 load
        drive_word(tbl[6], 1'b1, FMT_R);   // error word, old address
        exp_addr = BASE;
        drive_word(tbl[1], 1'b1, FMT_R);   // loads during clear -> BASE
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_cnt = 8'd0;
        check("clear_err_count", {24'b0, err_count}, 32'd0);
        drive_word(tbl[4], 1'b1, FMT_R);   // BASE + STEP
        wait_drain();
        check("post_clear_err_count", {24'b0, err_count}, 32'd0);

        // err_count saturation
        for (int k = 0; k < 260; k++) drive_word(tbl[25], 1'b1, FMT_R);
        wait_drain();
        check("err_count_sat", {24'b0, err_count}, {24'b0, exp_cnt});

        // Random round-trip, back-to-back
        for (int k = 0; k < 1000; k++) begin
            v.rd = 5'($urandom()); v.rs1 = 5'($urandom()); v.rs2 = 5'($urandom());
            v.f3 = 3'($urandom()); v.f7 = 7'($urandom());
            v.exp_instr = 32'd0; v.exp_err = 1'b0;
            case ($urandom_range(0, 4))
                0: begin
                    f = FMT_I;
                    case ($urandom_range(0, 2))
                        0: v.op = OP_IMM;
                        1: v.op = LOAD;
                        default: v.op = JALR;
                    endcase
                    t = int'($urandom_range(0, 4095)) - 2048;
                end
                1: begin f = FMT_S; v.op = STORE;  t = int'($urandom_range(0, 4095)) - 2048; end
                2: begin f = FMT_B; v.op = BRANCH; t = (int'($urandom_range(0, 4095)) - 2048) * 2; end
                3: begin
                    f = FMT_U;
                    v.op = ($urandom_range(0, 1) == 0) ? LUI : AUIPC;
                    u = $urandom();
                    t = int'(u & 32'hFFFF_F000);
                end
                default: begin
                    f = FMT_J; v.op = JAL;
                    t = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                end
            endcase
            v.imm = 32'(t);
            drive_word(v, 1'b0, f);
        end
        wait_drain();
        check("rt_err_count", {24'b0, err_count}, {24'b0, exp_cnt});

        // Reset mid-stream drops in-flight words
        drive_word(tbl[0], 1'b1, FMT_R);
        drive_word(tbl[1], 1'b1, FMT_R);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_addr = BASE; exp_cnt = 8'd0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_addr", out_addr, BASE);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_err_count", {24'b0, err_count}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("mid_rst_no_emit", {31'b0, out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
